// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding, bus field widths and
// acknowledge levels, used by the target and the master.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } target_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-flop synchronizer followed by a glitch filter that only
// changes its output after FILTER_LEN consecutive samples of the new level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic filt_out
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [1:0]    sync_d;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter restarts whenever the synchronized level agrees with the
    // filtered one, so any shorter excursion is simply forgotten.
    always_comb begin
        sync_d = {sync_q[0], raw_in};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_out = filt_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: filters SCL/SDA, detects START/STOP, matches a 7-bit
// address and exchanges bytes with a simple byte-wide local interface.
import i2c_pkg::*;

module i2c_target #(
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  busy,
    output logic                  addr_match,
    output logic                  rw,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  stop_det
);

    logic scl_f;
    logic sda_f;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (scl_in),
        .filt_out (scl_f)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (sda_in),
        .filt_out (sda_f)
    );

    target_state_e         state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_DATA_W-1:0] shift_q, shift_d;
    logic [I2C_DATA_W-1:0] rx_data_q, rx_data_d;
    logic                  scl_prev_q, scl_prev_d;
    logic                  sda_prev_q, sda_prev_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  rw_q, rw_d;
    logic                  ack_phase_q, ack_phase_d;
    logic                  addr_match_q, addr_match_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  stop_det_q, stop_det_d;
    logic                  tx_load;
    logic [I2C_DATA_W-1:0] rx_byte;

    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign scl_rise = scl_f & ~scl_prev_q;
    assign scl_fall = ~scl_f & scl_prev_q;
    assign start_ev = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_ev  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    // ack_phase marks that the first half of a two-fall acknowledge window
    // has passed (ADDR_ACK/RX_ACK) or that the master ACKed a read (TX_ACK).
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        scl_prev_d   = scl_f;
        sda_prev_d   = sda_f;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        rw_d         = rw_q;
        ack_phase_d  = ack_phase_q;
        addr_match_d = 1'b0;
        rx_valid_d   = 1'b0;
        stop_det_d   = 1'b0;
        tx_load      = 1'b0;
        rx_byte      = {shift_q[I2C_DATA_W-2:0], sda_f};

        if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_ev) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = busy_q;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == own_addr && own_addr != '0) begin
                                addr_match_d = 1'b1;
                                rw_d         = rx_byte[0];
                                ack_phase_d  = 1'b0;
                                state_d      = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else if (!rw_q) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RX;
                        end else begin
                            tx_load   = 1'b1;
                            shift_d   = tx_data;
                            sda_oe_d  = ~tx_data[7];
                            bit_cnt_d = '0;
                            state_d   = ST_TX;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = rx_byte;
                            rx_valid_d  = 1'b1;
                            ack_phase_d = 1'b0;
                            state_d     = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RX;
                        end
                    end
                end
                // Bit 7 went out on entry; each fall here ends one bit time.
                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            state_d     = ST_TX_ACK;
                        end else begin
                            shift_d   = {shift_q[I2C_DATA_W-2:0], 1'b0};
                            sda_oe_d  = ~shift_q[I2C_DATA_W-2];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (sda_f == ACK) begin
                            ack_phase_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        tx_load   = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = '0;
                        state_d   = ST_TX;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            rw_q         <= 1'b0;
            ack_phase_q  <= 1'b0;
            addr_match_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            rw_q         <= rw_d;
            ack_phase_q  <= ack_phase_d;
            addr_match_q <= addr_match_d;
            rx_valid_q   <= rx_valid_d;
            stop_det_q   <= stop_det_d;
        end
    end

    // tx_req has to coincide with the capture of tx_data, so it is decoded
    // directly rather than registered.
    assign tx_req     = tx_load & ~rst;
    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign addr_match = addr_match_q;
    assign rw         = rw_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign stop_det   = stop_det_q;

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint: the responder at the far end of the bus from the team's I2C master block. Oversamples SCL/SDA on the system clock, detects START/STOP/repeated-START, matches a 7-bit address, and moves data bytes between the bus and a simple byte-wide local interface. SDA is open-drain: the block only pulls SDA low or releases it. Standard/fast-mode only; no clock stretching, no general call, no 10-bit addressing.

## Interface
- FILTER_LEN, 3: consecutive equal samples required before a filtered line changes (glitch rejection, ≥1).
- clk  in  1  system clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- own_addr  in  7  target address; sampled when the address byte completes.
- scl_in  in  1  raw SCL from pad (asynchronous).
- sda_in  in  1  raw SDA from pad (asynchronous).
- sda_oe  out  1  1 = pull SDA low, 0 = release. Reset 0.
- busy  out  1  high from START until STOP or NACKed address. Reset 0.
- addr_match  out  1  one-cycle pulse on address match. Reset 0.
- rw  out  1  R/W bit of last matched address (1 = read). Reset 0.
- rx_data  out  8  last byte written by master. Reset 8'h00.
- rx_valid  out  1  one-cycle pulse, rx_data updated same cycle. Reset 0.
- tx_data  in  8  byte to send on read; must be valid in the cycle tx_req is high.
- tx_req  out  1  one-cycle pulse; tx_data is captured that cycle. Reset 0.
- stop_det  out  1  one-cycle pulse on STOP while busy. Reset 0.

## Operation
- Each line: 2-flop synchronizer, then filter; filtered value (reset 1) flips only after FILTER_LEN consecutive samples of the new value.
- Events on filtered lines: SCL rise/fall; START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
- IDLE: START -> ADDR, bit counter = 0, busy = 1.
- ADDR: shift SDA in on each SCL rise (MSB first). After 8th rise: if byte[7:1] == own_addr and own_addr != 0, pulse addr_match, latch rw = byte[0], -> ADDR_ACK; else -> IGNORE, busy = 0.
- ADDR_ACK: on next SCL fall assert sda_oe; on the following SCL fall: rw=0 -> release, -> RX; rw=1 -> pulse tx_req, load shifter with tx_data, sda_oe = ~tx_data[7], -> TX.
- RX: shift on SCL rise; on 8th rise update rx_data, pulse rx_valid, -> RX_ACK. Every written byte is ACKed (no backpressure).
- RX_ACK: assert sda_oe on next SCL fall, release on the one after, -> RX.
- TX: on each SCL fall after the first, shift and drive sda_oe = ~shifter[7]; on the SCL fall after 8th bit, release -> TX_ACK.
- TX_ACK: sample SDA on SCL rise: 0 (ACK) -> on next SCL fall pulse tx_req, load, drive bit 7, -> TX; 1 (NACK) -> IGNORE, SDA stays released.
- IGNORE: no drive; waits for START or STOP.
- Any state: START -> ADDR (repeated START; counter cleared, sda_oe released). STOP -> IDLE, sda_oe = 0, busy = 0, stop_det pulse if busy was 1. START/STOP take priority over SCL edge handling in the same cycle.

## Timing
- Input latency: raw pad change to filtered change = 2 + FILTER_LEN cycles.
- sda_oe changes one cycle after the filtered SCL-fall event; data sampled in the cycle of the filtered SCL-rise event.
- Requirement: SCL high and low phases, and SDA setup/hold relative to SCL, each ≥ FILTER_LEN + 4 clk cycles; otherwise behaviour undefined.
- rx_valid/addr_match/tx_req/stop_det: exactly one cycle each; never two in the same cycle except stop_det alone.
- rst mid-transfer: next cycle all outputs at reset values, state IDLE, filters = 1; bus transfer in progress is abandoned (block waits for next START).

## Structure
- Package i2c_pkg: target state enum, I2C_ADDR_W = 7, I2C_DATA_W = 8, ACK = 1'b0 / NACK = 1'b1 constants; shared with the master.
- Sub-module i2c_line_filter (synchronizer + FILTER_LEN glitch filter, 1-bit), instantiated for SCL and SDA.

## Test plan
- own_addr=7'h50; START, 0xA0, 0x3C, STOP -> ACK on both 9th clocks, addr_match with rw=0, rx_data=0x3C with single rx_valid, stop_det pulse, busy 0.
- START, 0xA2 (addr 0x51), 0x11, STOP -> sda_oe never asserted, no rx_valid/addr_match, busy drops after 8th bit, no stop_det.
- START, 0xA1; tx_data 0x5A then 0xC3; master ACKs byte 1, NACKs byte 2 -> SDA shows 0x5A then 0xC3 MSB first, two tx_req pulses, sda_oe 0 after NACK through STOP.
- START, 0xA0, 0x10, repeated START, 0xA1, read 1 byte NACK, STOP -> rx_valid with 0x10, then addr_match rw=1, one tx_req.
- SDA 1-cycle low glitch with SCL high, FILTER_LEN=3 -> no START detected, busy stays 0; 3+-cycle low -> START detected.
- rst asserted mid-byte of a read while sda_oe=1 -> sda_oe, busy, all pulses 0 next cycle; subsequent full write transaction completes normally.
